// File: rtl/trng_ctrl_pkg.sv
// Shared definitions for the TRNG round-robin scheduler: FSM state encoding
// and the TRNG restart pulse length.
package trng_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RST_TRNG = 2'd0,
        ST_WARMUP   = 2'd1,
        ST_SERVE    = 2'd2,
        ST_ALARM    = 2'd3
    } state_t;

    localparam int RST_CYCLES = 2;

endpackage

// File: rtl/trng_rr_scheduler_if.sv
// Bundle between the scheduler, the TRNG core and the requesters.
interface trng_rr_scheduler_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
);
    // A TRNG word moves when trng_read & trng_valid at a clock edge. A requester
    // holds its req bit until a one-cycle gnt pulse, which also qualifies dat.
    logic             trng_reset;
    logic             trng_read;
    logic [WIDTH-1:0] trng_dat;
    logic             trng_valid;
    logic [NREQ-1:0]  req;
    logic [NREQ-1:0]  gnt;
    logic [WIDTH-1:0] dat;
    logic             ready;
    logic             alarm;
    logic             alarm_clr;

    modport master (
        output trng_reset, trng_read, gnt, dat, ready, alarm,
        input  trng_dat, trng_valid, req, alarm_clr
    );

    modport slave (
        input  trng_reset, trng_read, gnt, dat, ready, alarm,
        output trng_dat, trng_valid, req, alarm_clr
    );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set bit of req at or above ptr,
// wrapping at NREQ, returned as one-hot, index and an any-request flag.
module rr_arbiter #(
    parameter  int NREQ = 4,
    localparam int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] onehot,
    output logic [PW-1:0]   index,
    output logic            any
);
    int            k;
    logic [PW-1:0] kk;

    always_comb begin
        onehot = '0;
        index  = '0;
        any    = 1'b0;
        k      = 0;
        kk     = '0;
        for (int i = 0; i < NREQ; i++) begin
            // explicit wrap keeps non-power-of-2 NREQ in range
            k = int'(ptr) + i;
            if (k >= NREQ) k = k - NREQ;
            kk = PW'(k);
            if (!any && req[kk]) begin
                any        = 1'b1;
                index      = kk;
                onehot[kk] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/trng_rr_scheduler.sv
// Owns TRNG restart and read strobe, discards warm-up words, shares words
// round-robin among requesters and runs a repetition-count health test.
module trng_rr_scheduler
    import trng_ctrl_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int WIDTH     = 8,
    parameter int WARMUP    = 16,
    parameter int RCT_LIMIT = 4
) (
    input  logic                i_clk,
    input  logic                i_reset_n,
    trng_rr_scheduler_if.master bus,
    output state_t              o_dbg_state
);
    localparam int PW  = $clog2(NREQ);
    localparam int WW  = $clog2(WARMUP + 1);
    localparam int RW  = $clog2(RCT_LIMIT);
    localparam int RW1 = RW + 1;
    localparam int CW  = $clog2(RST_CYCLES + 1);

    state_t           state;
    logic [CW-1:0]    rst_cnt;
    logic [PW-1:0]    ptr;
    logic [WW-1:0]    warm_cnt;
    logic [RW-1:0]    rep_cnt;
    logic [WIDTH-1:0] prev;
    logic             prev_vld;
    logic [NREQ-1:0]  gnt_q;
    logic [WIDTH-1:0] dat_q;
    logic             alarm_q;

    logic [NREQ-1:0]  masked_req;
    logic [NREQ-1:0]  arb_onehot;
    logic [PW-1:0]    arb_idx;
    logic             arb_any;
    logic             trng_read;
    logic             consume;
    logic             same;
    logic [RW:0]      rep_inc;
    logic             rct_trip;
    logic [RW-1:0]    rep_next;

    // a requester pulsed this cycle cannot win again until the pulse drops
    assign masked_req = bus.req & ~gnt_q;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req    (masked_req),
        .ptr    (ptr),
        .onehot (arb_onehot),
        .index  (arb_idx),
        .any    (arb_any)
    );

    assign trng_read = (state == ST_WARMUP) | ((state == ST_SERVE) & arb_any);
    assign consume   = trng_read & bus.trng_valid;
    assign same      = prev_vld & (bus.trng_dat == prev);
    assign rep_inc   = {1'b0, rep_cnt} + RW1'(1);
    assign rct_trip  = same & (rep_inc >= RW1'(RCT_LIMIT - 1));
    assign rep_next  = !same    ? '0 :
                       rct_trip ? RW'(RCT_LIMIT - 1) : rep_inc[RW-1:0];

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state    <= ST_RST_TRNG;
            rst_cnt  <= '0;
            ptr      <= '0;
            warm_cnt <= '0;
            rep_cnt  <= '0;
            prev     <= '0;
            prev_vld <= 1'b0;
            gnt_q    <= '0;
            dat_q    <= '0;
            alarm_q  <= 1'b0;
        end else begin
            gnt_q <= '0;
            case (state)
                ST_RST_TRNG: begin
                    warm_cnt <= '0;
                    rep_cnt  <= '0;
                    prev_vld <= 1'b0;
                    if (rst_cnt == CW'(RST_CYCLES - 1)) begin
                        rst_cnt <= '0;
                        state   <= ST_WARMUP;
                    end else begin
                        rst_cnt <= rst_cnt + CW'(1);
                    end
                end
                ST_WARMUP: if (consume) begin
                    prev     <= bus.trng_dat;
                    prev_vld <= 1'b1;
                    rep_cnt  <= rep_next;
                    warm_cnt <= warm_cnt + WW'(1);
                    if (rct_trip) begin
                        state   <= ST_ALARM;
                        alarm_q <= 1'b1;
                    end else if (warm_cnt == WW'(WARMUP - 1)) begin
                        state <= ST_SERVE;
                    end
                end
                ST_SERVE: if (consume) begin
                    prev     <= bus.trng_dat;
                    prev_vld <= 1'b1;
                    rep_cnt  <= rep_next;
                    // a failing word is swallowed: no grant, pointer stays put
                    if (rct_trip) begin
                        state   <= ST_ALARM;
                        alarm_q <= 1'b1;
                    end else begin
                        gnt_q <= arb_onehot;
                        dat_q <= bus.trng_dat;
                        ptr   <= (arb_idx == PW'(NREQ - 1)) ? '0 : arb_idx + PW'(1);
                    end
                end
                ST_ALARM: if (bus.alarm_clr) begin
                    state   <= ST_RST_TRNG;
                    rst_cnt <= '0;
                    alarm_q <= 1'b0;
                end
                default: state <= ST_RST_TRNG;
            endcase
        end
    end

    assign bus.trng_reset = ~i_reset_n | (state == ST_RST_TRNG);
    assign bus.trng_read  = trng_read;
    assign bus.gnt        = gnt_q;
    assign bus.dat        = dat_q;
    assign bus.ready      = (state == ST_SERVE);
    assign bus.alarm      = alarm_q;
    assign o_dbg_state    = state;
endmodule

// File: tb/tb_trng_rr_scheduler.sv
// Self-checking bench for trng_rr_scheduler: directed scenarios plus random
// traffic against a phase/history reference model.
module tb_trng_rr_scheduler;
  import trng_ctrl_pkg::*;

  localparam int NREQ = 4;
  localparam int W = 8;
  localparam int WARMUP = 16;
  localparam int RCT_LIMIT = 4;
  localparam int RST_CYC = 2;
  localparam int PH_RST = 0, PH_WARM = 1, PH_SERVE = 2, PH_ALARM = 3;

  logic clk = 1'b0;
  logic reset_n;
  state_t dbg_state;
  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] w_ctr = 8'h40;

  trng_rr_scheduler_if #(.NREQ(NREQ), .WIDTH(W)) bus();

  trng_rr_scheduler #(.NREQ(NREQ), .WIDTH(W), .WARMUP(WARMUP), .RCT_LIMIT(RCT_LIMIT)) dut (
    .i_clk(clk),
    .i_reset_n(reset_n),
    .bus(bus),
    .o_dbg_state(dbg_state)
  );

  // clock/reset block
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // reference model: phase, words consumed since restart, last winner
  int m_phase = PH_RST;
  int m_rst_left = RST_CYC;
  int m_warm_left = WARMUP;
  int m_next = 0;
  logic [NREQ-1:0] m_gnt = '0;
  logic [W-1:0] m_dat = '0;
  logic m_alarm = 1'b0;
  logic [W-1:0] hist[$];
  logic [W-1:0] exp_q[$];
  logic m_read;

  assign m_read = (m_phase == PH_WARM) || ((m_phase == PH_SERVE) && ((bus.req & ~m_gnt) != '0));

  always @(posedge clk) begin
    logic cons;
    int run;
    int win;
    int k;
    logic [NREQ-1:0] g;
    cons = m_read && bus.trng_valid;
    g = '0;
    if (!reset_n) begin
      m_phase = PH_RST; m_rst_left = RST_CYC; m_next = 0;
      m_dat = '0; m_alarm = 1'b0; hist.delete();
    end else begin
      case (m_phase)
        PH_RST: begin
          m_rst_left--;
          if (m_rst_left == 0) begin
            m_phase = PH_WARM; m_warm_left = WARMUP; hist.delete();
          end
        end
        PH_WARM, PH_SERVE: if (cons) begin
          hist.push_back(bus.trng_dat);
          run = 0;
          for (int i = hist.size() - 1; i >= 0; i--) begin
            if (hist[i] != bus.trng_dat) break;
            run++;
          end
          if (run >= RCT_LIMIT) begin
            m_phase = PH_ALARM; m_alarm = 1'b1;
          end else if (m_phase == PH_WARM) begin
            m_warm_left--;
            if (m_warm_left == 0) m_phase = PH_SERVE;
          end else begin
            win = -1;
            for (int i = 0; i < NREQ; i++) begin
              k = (m_next + i) % NREQ;
              if (win < 0 && bus.req[k] && !m_gnt[k]) win = k;
            end
            g[win] = 1'b1;
            m_dat = bus.trng_dat;
            m_next = (win + 1) % NREQ;
            exp_q.push_back(bus.trng_dat);
          end
        end
        PH_ALARM: if (bus.alarm_clr) begin
          m_phase = PH_RST; m_rst_left = RST_CYC; m_alarm = 1'b0;
        end
        default: ;
      endcase
    end
    m_gnt = g;
  end

  // driver: restart the TRNG (optionally via reset) and feed words until SERVE
  task automatic do_restart(input bit assert_rst);
    int budget;
    logic [W-1:0] wc;
    bus.req = '0; bus.alarm_clr = 1'b0; bus.trng_valid = 1'b1; wc = 8'h80;
    if (assert_rst) begin
      reset_n = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
    end
    budget = 0;
    while (bus.ready !== 1'b1 && budget < 100) begin
      bus.trng_dat = wc; wc++;
      @(negedge clk);
      budget++;
    end
    n_checks++;
    if (bus.ready !== 1'b1) begin
      n_errors++; $display("FAIL restart_timeout: ready=%b expected 1 within 100 cycles", bus.ready);
    end
  endtask

  task automatic test_reset();
    int hi;
    reset_n = 1'b0; bus.req = '0; bus.trng_valid = 1'b0; bus.alarm_clr = 1'b0; bus.trng_dat = '0;
    repeat (3) @(negedge clk);
    n_checks++; if (bus.trng_reset !== 1'b1) begin n_errors++; $display("FAIL reset_trng_reset: got %b expected 1", bus.trng_reset); end
    n_checks++; if (bus.gnt !== '0) begin n_errors++; $display("FAIL reset_gnt: got %b expected 0", bus.gnt); end
    n_checks++; if (bus.dat !== '0) begin n_errors++; $display("FAIL reset_dat: got %h expected 0", bus.dat); end
    n_checks++; if (bus.alarm !== 1'b0) begin n_errors++; $display("FAIL reset_alarm: got %b expected 0", bus.alarm); end
    n_checks++; if (bus.ready !== 1'b0) begin n_errors++; $display("FAIL reset_ready: got %b expected 0", bus.ready); end
    n_checks++; if (dbg_state !== ST_RST_TRNG) begin n_errors++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, ST_RST_TRNG); end
    reset_n = 1'b1;
    hi = 0;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (bus.trng_reset === 1'b1) hi++;
      @(negedge clk);
    end
    n_checks++; if (hi != RST_CYC) begin n_errors++; $display("FAIL trng_reset_len: got %0d cycles expected %0d", hi, RST_CYC); end
    n_checks++; if (dbg_state !== ST_WARMUP) begin n_errors++; $display("FAIL post_reset_state: got %0d expected %0d", dbg_state, ST_WARMUP); end
  endtask

  task automatic test_warmup();
    int done;
    done = 0;
    for (int budget = 0; budget < 300; budget++) begin
      n_checks++;
      if (bus.ready !== (done == WARMUP)) begin
        n_errors++; $display("FAIL warmup_ready: got %b after %0d consumes", bus.ready, done);
      end
      if (bus.ready === 1'b1) break;
      bus.trng_valid = ($urandom_range(0, 2) != 0);
      bus.trng_dat = w_ctr; w_ctr++;
      #1;
      n_checks++;
      if (bus.trng_read !== 1'b1 || bus.gnt !== '0) begin
        n_errors++; $display("FAIL warmup_read_gnt: read=%b gnt=%b expected read=1 gnt=0", bus.trng_read, bus.gnt);
      end
      if (bus.trng_read === 1'b1 && bus.trng_valid) done++;
      @(negedge clk);
    end
    n_checks++; if (done != WARMUP) begin n_errors++; $display("FAIL warmup_count: got %0d expected %0d", done, WARMUP); end
  endtask

  task automatic test_all_req();
    logic [NREQ-1:0] seq [5];
    logic [NREQ-1:0] prev;
    logic [W-1:0] last;
    seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    bus.req = '1; bus.trng_valid = 1'b1; prev = '0;
    for (int i = 0; i < 5; i++) begin
      bus.trng_dat = w_ctr; last = w_ctr; w_ctr++;
      @(negedge clk);
      n_checks++;
      if (bus.gnt !== seq[i] || bus.dat !== last) begin
        n_errors++; $display("FAIL all_req_grant%0d: got gnt=%b dat=%h expected gnt=%b dat=%h", i, bus.gnt, bus.dat, seq[i], last);
      end
      n_checks++;
      if ((bus.gnt & prev) != '0) begin
        n_errors++; $display("FAIL all_req_repeat%0d: got gnt=%b after %b expected different requester", i, bus.gnt, prev);
      end
      prev = bus.gnt;
    end
    bus.req = '0; bus.trng_valid = 1'b0;
  endtask

  task automatic test_pair();
    logic [NREQ-1:0] seq [3];
    logic [W-1:0] last;
    seq = '{4'b1000, 4'b0001, 4'b1000};
    bus.req = 4'b1001; bus.trng_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.trng_dat = w_ctr; last = w_ctr; w_ctr++;
      @(negedge clk);
      n_checks++;
      if (bus.gnt !== seq[i] || bus.dat !== last) begin
        n_errors++; $display("FAIL pair_grant%0d: got gnt=%b dat=%h expected gnt=%b dat=%h", i, bus.gnt, bus.dat, seq[i], last);
      end
    end
    bus.req = '0; bus.trng_valid = 1'b0;
  endtask

  task automatic test_single();
    bus.req = 4'b0010; bus.trng_valid = 1'b1; bus.trng_dat = 8'hA5;
    #1;
    n_checks++; if (bus.trng_read !== 1'b1) begin n_errors++; $display("FAIL single_read: got %b expected 1", bus.trng_read); end
    @(negedge clk);
    n_checks++;
    if (bus.gnt !== 4'b0010 || bus.dat !== 8'hA5) begin
      n_errors++; $display("FAIL single_grant: got gnt=%b dat=%h expected gnt=0010 dat=a5", bus.gnt, bus.dat);
    end
    bus.req = '0; bus.trng_dat = w_ctr; w_ctr++;
    @(negedge clk);
    n_checks++;
    if (bus.gnt !== '0 || bus.dat !== 8'hA5) begin
      n_errors++; $display("FAIL single_hold: got gnt=%b dat=%h expected gnt=0000 dat=a5", bus.gnt, bus.dat);
    end
    bus.trng_valid = 1'b0;
  endtask

  task automatic test_random();
    logic [NREQ-1:0] nr;
    logic [W-1:0] exp_w;
    exp_q.delete();
    for (int c = 0; c < 1200; c++) begin
      for (int k = 0; k < NREQ; k++)
        nr[k] = bus.gnt[k] ? ($urandom_range(0, 3) == 0) : (bus.req[k] | ($urandom_range(0, 2) == 0));
      bus.req = nr;
      bus.trng_valid = ($urandom_range(0, 3) != 0);
      bus.trng_dat = ($urandom_range(0, 3) != 0) ? 8'($urandom_range(0, 1)) : 8'($urandom);
      bus.alarm_clr = ($urandom_range(0, 7) == 0);
      #1;
      n_checks++;
      if (bus.trng_read !== m_read || bus.trng_reset !== (m_phase == PH_RST)) begin
        n_errors++; $display("FAIL rand_strobes c%0d: got read=%b trst=%b expected read=%b trst=%b", c, bus.trng_read, bus.trng_reset, m_read, (m_phase == PH_RST));
      end
      @(negedge clk);
      n_checks++;
      if (bus.gnt !== m_gnt || bus.dat !== m_dat) begin
        n_errors++; $display("FAIL rand_grant c%0d: got gnt=%b dat=%h expected gnt=%b dat=%h", c, bus.gnt, bus.dat, m_gnt, m_dat);
      end
      n_checks++;
      if (bus.ready !== (m_phase == PH_SERVE) || bus.alarm !== m_alarm) begin
        n_errors++; $display("FAIL rand_status c%0d: got ready=%b alarm=%b expected ready=%b alarm=%b", c, bus.ready, bus.alarm, (m_phase == PH_SERVE), m_alarm);
      end
      if (bus.gnt != '0) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++; $display("FAIL rand_scoreboard c%0d: got dat=%h expected no delivery", c, bus.dat);
        end else begin
          exp_w = exp_q.pop_front();
          if (bus.dat !== exp_w) begin
            n_errors++; $display("FAIL rand_scoreboard c%0d: got dat=%h expected %h", c, bus.dat, exp_w);
          end
        end
      end
      n_checks++;
      if (exp_q.size() != 0) begin
        n_errors++; $display("FAIL rand_undelivered c%0d: got %0d pending words expected 0", c, exp_q.size());
        exp_q.delete();
      end
    end
    bus.req = '0; bus.trng_valid = 1'b0; bus.alarm_clr = 1'b0;
  endtask

  task automatic test_rct();
    logic [W-1:0] wv [6];
    wv = '{8'h10, 8'h11, 8'h3C, 8'h3C, 8'h3C, 8'h3C};
    do_restart(1'b1);
    bus.req = '1; bus.trng_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.trng_dat = wv[i];
      @(negedge clk);
      n_checks++;
      if (i < 5) begin
        if (bus.gnt === '0 || bus.dat !== wv[i]) begin
          n_errors++; $display("FAIL rct_deliver%0d: got gnt=%b dat=%h expected grant with dat=%h", i, bus.gnt, bus.dat, wv[i]);
        end
      end else if (bus.gnt !== '0 || bus.alarm !== 1'b1 || bus.ready !== 1'b0 || bus.trng_read !== 1'b0) begin
        n_errors++; $display("FAIL rct_trip: got gnt=%b alarm=%b ready=%b read=%b expected 0000 1 0 0", bus.gnt, bus.alarm, bus.ready, bus.trng_read);
      end
    end
    n_checks++; if (dbg_state !== ST_ALARM) begin n_errors++; $display("FAIL rct_state: got %0d expected %0d", dbg_state, ST_ALARM); end
    bus.alarm_clr = 1'b1;
    @(negedge clk);
    bus.alarm_clr = 1'b0;
    n_checks++;
    if (bus.alarm !== 1'b0 || bus.trng_reset !== 1'b1 || dbg_state !== ST_RST_TRNG) begin
      n_errors++; $display("FAIL clr_first: got alarm=%b trst=%b state=%0d expected 0 1 %0d", bus.alarm, bus.trng_reset, dbg_state, ST_RST_TRNG);
    end
    @(negedge clk);
    n_checks++; if (bus.trng_reset !== 1'b1) begin n_errors++; $display("FAIL clr_second: got trst=%b expected 1", bus.trng_reset); end
    @(negedge clk);
    n_checks++;
    if (bus.trng_reset !== 1'b0 || dbg_state !== ST_WARMUP) begin
      n_errors++; $display("FAIL clr_done: got trst=%b state=%0d expected 0 %0d", bus.trng_reset, dbg_state, ST_WARMUP);
    end
    test_warmup();
    bus.req = '0; bus.trng_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    bus.req = 4'b0100; bus.trng_valid = 1'b1; bus.trng_dat = 8'h77; reset_n = 1'b0;
    #1;
    n_checks++; if (bus.trng_read !== 1'b1) begin n_errors++; $display("FAIL mid_read: got %b expected 1", bus.trng_read); end
    @(negedge clk);
    n_checks++;
    if (bus.gnt !== '0 || bus.dat !== '0 || bus.alarm !== 1'b0 || bus.ready !== 1'b0) begin
      n_errors++; $display("FAIL mid_outputs: got gnt=%b dat=%h alarm=%b ready=%b expected all 0", bus.gnt, bus.dat, bus.alarm, bus.ready);
    end
    n_checks++;
    if (dbg_state !== ST_RST_TRNG || bus.trng_reset !== 1'b1) begin
      n_errors++; $display("FAIL mid_state: got state=%0d trst=%b expected %0d 1", dbg_state, bus.trng_reset, ST_RST_TRNG);
    end
    reset_n = 1'b1;
    do_restart(1'b0);
    bus.req = '1; bus.trng_valid = 1'b1; bus.trng_dat = 8'h99;
    @(negedge clk);
    n_checks++;
    if (bus.gnt !== 4'b0001 || bus.dat !== 8'h99) begin
      n_errors++; $display("FAIL mid_ptr: got gnt=%b dat=%h expected gnt=0001 dat=99", bus.gnt, bus.dat);
    end
    bus.req = '0; bus.trng_valid = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    bus.req = '0; bus.trng_valid = 1'b0; bus.alarm_clr = 1'b0; bus.trng_dat = '0;
    test_reset();
    test_warmup();
    test_all_req();
    test_pair();
    test_single();
    test_random();
    test_rct();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
